// File: rtl/rf_wb_queue_pkg.sv
// Shared register-file writeback types: register address/data widths and
// the {addr, data} entry held in the writeback queue.
package rf_wb_queue_pkg;

   localparam int REG_AW = 4;
   localparam int DATA_W = 16;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   function automatic wb_entry_t make_entry(input logic [REG_AW-1:0] addr,
                                            input logic [DATA_W-1:0] data);
      wb_entry_t e;
      e.addr = addr;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/rf_wb_queue_byp.sv
// Bypass lookup: scans the queued writebacks from oldest to youngest and
// returns the data of the youngest valid entry targeting rd_addr.
module rf_byp_match
   import rf_wb_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wb_entry_t [DEPTH-1:0]         entries,
   input  logic [DEPTH-1:0]              vld_mask,
   input  logic [$clog2(DEPTH)-1:0]      head,
   input  logic [REG_AW-1:0]             rd_addr,
   output logic                          byp_vld,
   output logic [DATA_W-1:0]             byp_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] slot;

   // Later (younger) matches overwrite earlier ones, so the last hit wins.
   always_comb begin
      byp_vld  = 1'b0;
      byp_data = '0;
      slot     = head;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PTR_W'(i);
         if (vld_mask[slot] && (entries[slot].addr == rd_addr) && (rd_addr != '0)) begin
            byp_vld  = 1'b1;
            byp_data = entries[slot].data;
         end
      end
   end

endmodule

// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: merges load and ALU writebacks into one
// in-order circular queue draining through a single RF write port.
module rf_wb_queue
   import rf_wb_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_vld,
   input  logic [3:0]        mem_addr,
   input  logic [15:0]       mem_data,
   output logic              mem_rdy,
   input  logic              alu_vld,
   input  logic [3:0]        alu_addr,
   input  logic [15:0]       alu_data,
   output logic              alu_rdy,
   output logic              rf_we,
   output logic [3:0]        rf_dst_addr,
   output logic [15:0]       rf_dst,
   input  logic [3:0]        p0_addr,
   input  logic [3:0]        p1_addr,
   output logic              p0_byp_vld,
   output logic [15:0]       p0_byp_data,
   output logic              p1_byp_vld,
   output logic [15:0]       p1_byp_data,
   input  logic              hlt,
   output logic              drained
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   wb_entry_t [DEPTH-1:0] entries_q, entries_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic                  rdy;
   logic                  mem_en;
   logic                  alu_en;
   logic                  deq;
   logic [CNT_W-1:0]      enq_cnt;
   logic [PTR_W-1:0]      alu_slot;
   logic [PTR_W-1:0]      offs;
   logic [DEPTH-1:0]      vld_mask;

   // Two free slots are required so both sources can always be taken together.
   assign rdy     = ((DEPTH_C - count_q) >= CNT_W'(2)) & ~hlt;
   assign mem_rdy = rdy;
   assign alu_rdy = rdy;

   // Writes to R0 are handshaken but never allocate an entry.
   assign mem_en  = mem_vld & rdy & (mem_addr != '0);
   assign alu_en  = alu_vld & rdy & (alu_addr != '0);
   assign deq     = (count_q != '0);
   assign enq_cnt = CNT_W'(mem_en) + CNT_W'(alu_en);

   always_comb begin
      entries_d = entries_q;
      alu_slot  = wr_ptr_q + PTR_W'(mem_en);
      if (mem_en) begin
         entries_d[wr_ptr_q] = make_entry(mem_addr, mem_data);
      end
      if (alu_en) begin
         entries_d[alu_slot] = make_entry(alu_addr, alu_data);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      wr_ptr_d = wr_ptr_q + enq_cnt[PTR_W-1:0];
      count_d  = count_q + enq_cnt - CNT_W'(deq);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i].addr <= '0;
         end
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         entries_q <= entries_d;
      end
   end

   // A slot is live when its distance from the head is below the fill count.
   always_comb begin
      vld_mask = '0;
      offs     = '0;
      for (int s = 0; s < DEPTH; s++) begin
         offs        = PTR_W'(s) - rd_ptr_q;
         vld_mask[s] = ({1'b0, offs} < count_q);
      end
   end

   assign rf_we       = deq;
   assign rf_dst_addr = deq ? entries_q[rd_ptr_q].addr : '0;
   assign rf_dst      = deq ? entries_q[rd_ptr_q].data : '0;
   assign drained     = hlt & (count_q == '0);

   rf_byp_match #(.DEPTH(DEPTH)) u_byp_p0 (
      .entries  (entries_q),
      .vld_mask (vld_mask),
      .head     (rd_ptr_q),
      .rd_addr  (p0_addr),
      .byp_vld  (p0_byp_vld),
      .byp_data (p0_byp_data)
   );

   rf_byp_match #(.DEPTH(DEPTH)) u_byp_p1 (
      .entries  (entries_q),
      .vld_mask (vld_mask),
      .head     (rd_ptr_q),
      .rd_addr  (p1_addr),
      .byp_vld  (p1_byp_vld),
      .byp_data (p1_byp_data)
   );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: a queue model predicts ready, writes,
// bypass and drained every cycle, plus directed scenario checks.
module tb_rf_wb_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        mem_vld, alu_vld;
   logic [3:0]  mem_addr, alu_addr;
   logic [15:0] mem_data, alu_data;
   logic        mem_rdy, alu_rdy;
   logic        rf_we;
   logic [3:0]  rf_dst_addr;
   logic [15:0] rf_dst;
   logic [3:0]  p0_addr, p1_addr;
   logic        p0_byp_vld, p1_byp_vld;
   logic [15:0] p0_byp_data, p1_byp_data;
   logic        hlt;
   logic        drained;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 0;

   logic        s_we, s_rdy, s_drained, s_p0v;
   logic [3:0]  s_addr;
   logic [15:0] s_dst, s_p0d;

   rf_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_vld     (mem_vld),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_rdy     (mem_rdy),
      .alu_vld     (alu_vld),
      .alu_addr    (alu_addr),
      .alu_data    (alu_data),
      .alu_rdy     (alu_rdy),
      .rf_we       (rf_we),
      .rf_dst_addr (rf_dst_addr),
      .rf_dst      (rf_dst),
      .p0_addr     (p0_addr),
      .p1_addr     (p1_addr),
      .p0_byp_vld  (p0_byp_vld),
      .p0_byp_data (p0_byp_data),
      .p1_byp_vld  (p1_byp_vld),
      .p1_byp_data (p1_byp_data),
      .hlt         (hlt),
      .drained     (drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic byp_model(input logic [3:0] a, output logic v, output logic [15:0] d);
      v = 1'b0;
      d = '0;
      if (a != 4'd0) begin
         foreach (sb[i]) begin
            if (sb[i].addr == a) begin
               v = 1'b1;
               d = sb[i].data;
            end
         end
      end
   endtask

   task automatic drive(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                        input logic av, input logic [3:0] aa, input logic [15:0] ad);
      mem_vld  = mv;
      mem_addr = ma;
      mem_data = md;
      alu_vld  = av;
      alu_addr = aa;
      alu_data = ad;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
   endtask

   // One clock: check outputs mid-cycle against the model, then advance it.
   task automatic tick();
      logic        exp_rdy, exp_we, bv;
      logic [15:0] bd;
      exp_t        e;
      @(negedge clk);
      exp_rdy   = ((DEPTH - sb.size()) >= 2) && !hlt;
      exp_we    = (sb.size() != 0);
      s_we      = rf_we;
      s_rdy     = mem_rdy;
      s_drained = drained;
      s_addr    = rf_dst_addr;
      s_dst     = rf_dst;
      s_p0v     = p0_byp_vld;
      s_p0d     = p0_byp_data;
      if (chk_en) begin
         chk_eq("mem_rdy", 32'(mem_rdy), 32'(exp_rdy));
         chk_eq("alu_rdy", 32'(alu_rdy), 32'(exp_rdy));
         chk_eq("rf_we", 32'(rf_we), 32'(exp_we));
         chk_eq("rf_dst_addr", 32'(rf_dst_addr), exp_we ? 32'(sb[0].addr) : 32'd0);
         chk_eq("rf_dst", 32'(rf_dst), exp_we ? 32'(sb[0].data) : 32'd0);
         chk_eq("drained", 32'(drained), 32'(hlt && (sb.size() == 0)));
         byp_model(p0_addr, bv, bd);
         chk_eq("p0_byp_vld", 32'(p0_byp_vld), 32'(bv));
         chk_eq("p0_byp_data", 32'(p0_byp_data), 32'(bd));
         byp_model(p1_addr, bv, bd);
         chk_eq("p1_byp_vld", 32'(p1_byp_vld), 32'(bv));
         chk_eq("p1_byp_data", 32'(p1_byp_data), 32'(bd));
      end
      if (rst) begin
         sb.delete();
      end else begin
         if (sb.size() != 0) void'(sb.pop_front());
         if (exp_rdy && mem_vld && (mem_addr != 4'd0)) begin
            e.addr = mem_addr;
            e.data = mem_data;
            sb.push_back(e);
         end
         if (exp_rdy && alu_vld && (alu_addr != 4'd0)) begin
            e.addr = alu_addr;
            e.data = alu_data;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill_three();
      drive(1'b1, 4'($urandom_range(1, 15)), 16'($urandom), 1'b1, 4'($urandom_range(1, 15)), 16'($urandom));
      tick();
      drive(1'b1, 4'($urandom_range(1, 15)), 16'($urandom), 1'b1, 4'($urandom_range(1, 15)), 16'($urandom));
      tick();
   endtask

   initial begin
      int   n_wr;
      logic hw_drained [5];
      logic hw_rdy [5];

      rst = 1'b1;
      hlt = 1'b1;
      p0_addr = 4'd0;
      p1_addr = 4'd0;
      idle();

      // Reset state
      tick();
      chk_en = 1;
      tick();
      chk_eq("rst_we", 32'(s_we), 32'd0);
      chk_eq("rst_drained", 32'(s_drained), 32'd1);
      chk_eq("rst_rdy_hlt", 32'(s_rdy), 32'd0);
      rst = 1'b0;
      hlt = 1'b0;
      tick();
      chk_eq("idle_rdy", 32'(s_rdy), 32'd1);
      chk_eq("idle_drained", 32'(s_drained), 32'd0);

      // Single write
      drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0);
      tick();
      idle();
      tick();
      chk_eq("single_we_c1", 32'(s_we), 32'd1);
      chk_eq("single_addr_c1", 32'(s_addr), 32'd3);
      chk_eq("single_data_c1", 32'(s_dst), 32'h1234);
      tick();
      chk_eq("single_we_c2", 32'(s_we), 32'd0);

      // Simultaneous requests to R5 with bypass
      p0_addr = 4'd5;
      drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'hBBBB);
      tick();
      idle();
      tick();
      chk_eq("simul_addr_c1", 32'(s_addr), 32'd5);
      chk_eq("simul_data_c1", 32'(s_dst), 32'hAAAA);
      chk_eq("byp_vld_c1", 32'(s_p0v), 32'd1);
      chk_eq("byp_data_c1", 32'(s_p0d), 32'hBBBB);
      tick();
      chk_eq("simul_data_c2", 32'(s_dst), 32'hBBBB);
      chk_eq("byp_data_c2", 32'(s_p0d), 32'hBBBB);
      tick();
      chk_eq("byp_vld_c3", 32'(s_p0v), 32'd0);
      chk_eq("simul_we_c3", 32'(s_we), 32'd0);

      // R0 discard
      drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hDEAD);
      tick();
      idle();
      tick();
      chk_eq("r0_no_we", 32'(s_we), 32'd0);

      // Backpressure: both sources requesting every cycle
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 4'($urandom_range(1, 15)), 16'($urandom), 1'b1, 4'($urandom_range(1, 15)), 16'($urandom));
         p0_addr = 4'($urandom_range(0, 15));
         p1_addr = 4'($urandom_range(0, 15));
         tick();
         if (i > 0) chk_eq("bp_write_per_cycle", 32'(s_we), 32'd1);
      end
      idle();
      for (int i = 0; i < 5; i++) tick();
      chk_eq("bp_drained_we", 32'(s_we), 32'd0);

      // Halt with three entries queued
      fill_three();
      hlt = 1'b1;
      n_wr = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_wr += int'(s_we);
         hw_drained[i] = s_drained;
         hw_rdy[i] = s_rdy;
      end
      chk_eq("hlt_rdy_now", 32'(hw_rdy[0]), 32'd0);
      chk_eq("hlt_rdy_late", 32'(hw_rdy[4]), 32'd0);
      chk_eq("hlt_writes", 32'(n_wr), 32'd3);
      chk_eq("hlt_drained_c2", 32'(hw_drained[2]), 32'd0);
      chk_eq("hlt_drained_c3", 32'(hw_drained[3]), 32'd1);
      chk_eq("hlt_drained_c4", 32'(hw_drained[4]), 32'd1);
      hlt = 1'b0;
      idle();
      tick();

      // Reset with three entries pending; enqueue blocked on the reset edge
      fill_three();
      rst = 1'b1;
      drive(1'b1, 4'd9, 16'h9999, 1'b1, 4'd10, 16'hAAAA);
      tick();
      rst = 1'b0;
      idle();
      tick();
      chk_eq("rstmid_we_c1", 32'(s_we), 32'd0);
      chk_eq("rstmid_rdy", 32'(s_rdy), 32'd1);
      tick();
      chk_eq("rstmid_we_c2", 32'(s_we), 32'd0);
      drive(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'd0);
      tick();
      idle();
      tick();
      chk_eq("rstmid_next_we", 32'(s_we), 32'd1);
      chk_eq("rstmid_next_addr", 32'(s_addr), 32'd7);
      chk_eq("rstmid_next_data", 32'(s_dst), 32'h7777);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports mem_vld, mem_addr[3:0], mem_data[15:0] as inputs, and mem_rdy as a 1-bit output: load-writeback request.
REQ-004 SHALL have ports alu_vld, alu_addr[3:0], alu_data[15:0] as inputs, and alu_rdy as a 1-bit output: ALU-writeback request.
REQ-005 SHALL have outputs rf_we (1 bit), rf_dst_addr (4 bits) and rf_dst (16 bits): the single register-file write port.
REQ-006 SHALL have inputs p0_addr[3:0] and p1_addr[3:0]: the current register-file read addresses.
REQ-007 SHALL have outputs p0_byp_vld (1 bit) and p0_byp_data (16 bits): bypass for a pending write to p0_addr.
REQ-008 SHALL have outputs p1_byp_vld (1 bit) and p1_byp_data (16 bits): bypass for a pending write to p1_addr.
REQ-009 SHALL have input hlt (1 bit): drain request; and output drained (1 bit): queue empty while halting.
REQ-010 SHALL use parameter DEPTH, default 4: queue entries, a power of two, at least 2.

Function
REQ-011 SHALL hold pending writes in one shared in-order circular queue of DEPTH entries {addr, data}, with pointers rd_ptr and wr_ptr and a count of 0..DEPTH.
REQ-012 SHALL drive mem_rdy = alu_rdy = (DEPTH - count >= 2) & ~hlt, combinationally from registered state, so both sources are accepted together or neither is.
REQ-013 SHALL enqueue on a clock edge where vld & rdy; when both sources enqueue in one cycle, the mem entry SHALL occupy the older slot and the alu entry the younger.
REQ-014 SHALL accept and silently discard any request whose addr = 0: ready is still honoured, no entry is allocated, and count is unchanged.
REQ-015 SHALL drive rf_we = (count != 0), with rf_dst_addr/rf_dst taken from the head entry; the head SHALL dequeue on every edge where rf_we = 1.
REQ-016 SHALL give a one-cycle accept-to-write latency: a request accepted at edge N into an empty queue appears on rf_we in the cycle after edge N.
REQ-017 SHALL allow enqueue (0, 1 or 2 entries) and dequeue (1 entry) on the same edge: count_next = count + enq - deq, with pointers wrapping modulo DEPTH.
REQ-018 SHALL assert pX_byp_vld when any valid entry has addr == pX_addr and pX_addr != 0.
REQ-019 SHALL drive pX_byp_data from the youngest matching entry; pX_byp_data SHALL be 0 when pX_byp_vld = 0.
REQ-020 SHALL compute bypass combinationally from registered entries only; same-cycle incoming requests SHALL NOT be visible to bypass.
REQ-021 SHALL deassert both ready outputs while hlt = 1, keep draining, and assert drained = hlt & (count == 0).
REQ-022 SHALL NOT let overflow occur by construction; underflow SHALL be impossible because dequeue only happens when count != 0.

Reset
REQ-023 SHALL, on clk rising with rst = 1, clear rd_ptr, wr_ptr and count to 0 and clear all entry addr fields to 0.
REQ-024 SHALL hold these output values during and after reset: rf_we = 0, rf_dst_addr = 0, rf_dst = 0, byp_vld = 0, byp_data = 0, and drained = hlt.
REQ-025 SHALL, on reset mid-operation, discard all pending entries without writing them, and block enqueue on that edge.

Structure
REQ-026 SHALL place the shared package constants REG_AW = 4, DATA_W = 16 and the entry typedef {addr, data} in the existing CPU package.
REQ-027 SHALL implement bypass through one sub-module, rf_byp_match, instantiated twice: inputs are the entries, the valid mask, head position and read address; outputs are vld and data from the youngest match.

Verification
REQ-028 SHALL check single write: mem_vld=1, addr=3, data=0x1234 at edge 0 -> rf_we=1, rf_dst_addr=3, rf_dst=0x1234 in cycle 1, and rf_we=0 in cycle 2.
REQ-029 SHALL check simultaneous requests: mem(5,0xAAAA) and alu(5,0xBBBB) at the same edge -> R5 written 0xAAAA then 0xBBBB on consecutive cycles.
REQ-030 SHALL check bypass, same case: with p0_addr=5 -> p0_byp_vld=1 and p0_byp_data=0xBBBB in cycle 1; p0_byp_data=0xBBBB in cycle 2; p0_byp_vld=0 in cycle 3.
REQ-031 SHALL check R0 and backpressure: alu addr=0 -> no rf_we; with both sources requesting every cycle and DEPTH=4, ready never lets count exceed 4, and after the first cycle one write issues per cycle.
REQ-032 SHALL check halt: 3 entries queued then hlt=1 -> rdy=0 immediately, 3 writes issue, and drained=1 from the cycle count reaches 0.
REQ-033 SHALL check reset mid-operation: rst with 3 entries pending -> no further rf_we, count=0, and the next accepted request writes normally.
